// File: rtl/xc_divrem_iter.sv
// Iterative signed/unsigned divide/remainder unit, BITS_PER_CYCLE restoring steps per clock.
// Optional XC_DIVREM_FAST_PATH_EN: divide-by-zero and signed overflow retire straight to DONE.
module xc_divrem_iter #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            op_signed,
    input  logic            op_rem,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int unsigned N    = XLEN / BITS_PER_CYCLE;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFix,
        StDone
    } state_e;

    state_e          state_q;
    logic            op_rem_q;
    logic            neg_q_q;
    logic            neg_r_q;
    logic [XLEN-1:0] q_q;
    logic [XLEN:0]   r_q;
    logic [XLEN-1:0] d_q;
    logic [CntW-1:0] count_q;
    logic [XLEN-1:0] result_q;

    logic [XLEN-1:0] q_d;
    logic [XLEN:0]   r_d;
    logic [XLEN-1:0] rs1_abs;
    logic [XLEN-1:0] rs2_abs;
    logic            neg_q_in;
    logic            neg_r_in;
    logic [XLEN-1:0] r_low;
    logic [XLEN-1:0] fix_res;

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign result    = result_q;

    assign rs1_abs  = (op_signed & rs1[XLEN-1]) ? -rs1 : rs1;
    assign rs2_abs  = (op_signed & rs2[XLEN-1]) ? -rs2 : rs2;
    assign neg_q_in = op_signed & (rs1[XLEN-1] ^ rs2[XLEN-1]) & (rs2 != '0);
    assign neg_r_in = op_signed & rs1[XLEN-1];

    // Chained restoring sub-steps; R never exceeds 2*D so XLEN+1 bits suffice.
    always_comb begin
        q_d = q_q;
        r_d = r_q;
        for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
            r_d = {r_d[XLEN-1:0], q_d[XLEN-1]};
            q_d = {q_d[XLEN-2:0], 1'b0};
            if (r_d >= {1'b0, d_q}) begin
                r_d    = r_d - {1'b0, d_q};
                q_d[0] = 1'b1;
            end
        end
    end

    assign r_low   = r_q[XLEN-1:0];
    assign fix_res = op_rem_q ? (neg_r_q ? -r_low : r_low) : (neg_q_q ? -q_q : q_q);

`ifdef XC_DIVREM_FAST_PATH_EN
    logic            div_zero;
    logic            sgn_ovf;
    logic            fast_hit;
    logic [XLEN-1:0] fast_res;

    assign div_zero = (rs2 == '0);
    assign sgn_ovf  = op_signed & (rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (&rs2);
    assign fast_hit = div_zero | sgn_ovf;

    always_comb begin
        fast_res = '0;
        if (div_zero) begin
            fast_res = op_rem ? rs1 : '1;
        end else begin
            fast_res = op_rem ? '0 : rs1;
        end
    end
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            op_rem_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            q_q      <= '0;
            r_q      <= '0;
            d_q      <= '0;
            count_q  <= '0;
            result_q <= '0;
        end else if (flush) begin
            state_q <= StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        op_rem_q <= op_rem;
                        neg_q_q  <= neg_q_in;
                        neg_r_q  <= neg_r_in;
                        q_q      <= rs1_abs;
                        d_q      <= rs2_abs;
                        r_q      <= '0;
                        count_q  <= '0;
`ifdef XC_DIVREM_FAST_PATH_EN
                        if (fast_hit) begin
                            result_q <= fast_res;
                            state_q  <= StDone;
                        end else begin
                            state_q <= StRun;
                        end
`else
                        state_q <= StRun;
`endif
                    end
                end
                StRun: begin
                    q_q     <= q_d;
                    r_q     <= r_d;
                    count_q <= count_q + CntW'(1);
                    if (count_q == LastCnt) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    result_q <= fix_res;
                    state_q  <= StDone;
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
